multi_channel_burst_scheduler: RTL and testbench

Parametrised N-channel successor to the two-engine ping-pong write scheduler. It splits one incoming beat stream into fixed-size bursts and dispatches them round-robin across `NUM_CH` AXI write-master engines. It pre-arms the next engine while the current one streams, and supports linear-fill or ring-buffer (wrap) mode. It halts and restarts from the base address when any HP-port FIFO crosses a warning threshold. It sits between the data source and the per-channel burst-writer engines.

---
 rtl/multi_channel_burst_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_multi_channel_burst_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_burst_scheduler
// Purpose  : Splits one beat stream into fixed-size bursts and dispatches them
//            round-robin across NUM_CH AXI write-master engines. The next
//            engine is pre-armed while the current one streams. The buffer
//            window can be filled linearly or used as a ring. If any HP FIFO
//            reaches the warning level, the run halts and restarts from the
//            base address.
// Ports    : clk, rst                      clock, sync active-high reset
//            start, wrap_mode              run control (start edge launches)
//            data_en, data                 incoming beat stream
//            base_addr, end_addr           buffer window [base, end)
//            warn_thres, cancel_thres      FIFO hysteresis thresholds
//            fifo_cnt, txn_done, m_wready  per-engine feedback
//            init_txn, bias_addr           per-engine arm pulse and address
//            ch_data_en, ch_data           forwarded beat (1-cycle latency)
//            wready_out, active_ch         currently streaming engine
//            write_done, halted, protocol_err, restart_count, state  status
// Revision : 1.0  initial release
// ============================================================================
module multi_channel_burst_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         wrap_mode,
    input  logic                         data_en,
    input  logic [DATA_WIDTH-1:0]        data,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [ADDR_WIDTH-1:0]        end_addr,
    input  logic [CNT_WIDTH-1:0]         warn_thres,
    input  logic [CNT_WIDTH-1:0]         cancel_thres,
    input  logic [NUM_CH*CNT_WIDTH-1:0]  fifo_cnt,
    input  logic [NUM_CH-1:0]            txn_done,
    input  logic [NUM_CH-1:0]            m_wready,
    output logic [NUM_CH-1:0]            init_txn,
    output logic [NUM_CH*ADDR_WIDTH-1:0] bias_addr,
    output logic [NUM_CH-1:0]            ch_data_en,
    output logic [DATA_WIDTH-1:0]        ch_data,
    output logic                         wready_out,
    output logic [CH_W-1:0]              active_ch,
    output logic                         write_done,
    output logic                         halted,
    output logic                         protocol_err,
    output logic [15:0]                  restart_count,
    output logic [2:0]                   state
);
    localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    // One extra bit so window compares cannot wrap near the top of memory.
    localparam logic [ADDR_WIDTH:0]   c_BURST_EXT  = (ADDR_WIDTH+1)'(BURST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] c_BURST_ADDR = ADDR_WIDTH'(BURST_BYTES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_STREAM    = 3'd3,
        S_DONE      = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_start_q;
    logic                  r_data_en_q;
    logic                  r_wrap;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_end;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [CH_W-1:0]       r_active_ch;
    logic                  r_armed;
    logic [ADDR_WIDTH-1:0] r_bias [NUM_CH];

    logic [NUM_CH-1:0]     w_warn_vec;
    logic [NUM_CH-1:0]     w_clear_vec;

    function automatic logic [CH_W-1:0] f_next_ch(input logic [CH_W-1:0] ch);
        if (ch == CH_W'(NUM_CH - 1)) begin
            return '0;
        end
        return ch + CH_W'(1);
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign w_warn_vec[gi]  = (fifo_cnt[gi*CNT_WIDTH +: CNT_WIDTH] >= warn_thres);
            assign w_clear_vec[gi] = (fifo_cnt[gi*CNT_WIDTH +: CNT_WIDTH] <= cancel_thres);
            assign bias_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] = r_bias[gi];
        end
    endgenerate

    logic [NUM_CH-1:0]     w_active_oh;
    logic                  w_halt, w_start_rise, w_data_rise, w_done_active, w_stray;
    logic                  w_fits, w_can_arm, w_enter, w_switch, w_fwd, w_win_small;
    logic [CH_W-1:0]       w_nxt, w_nxt2, w_prearm_ch, w_fwd_ch;
    logic [ADDR_WIDTH-1:0] w_arm_addr;

    assign w_active_oh   = NUM_CH'(1) << r_active_ch;
    assign w_halt        = ((r_state == S_WAIT_DATA) || (r_state == S_STREAM)) && (|w_warn_vec);
    assign w_start_rise  = start && !r_start_q;
    assign w_data_rise   = data_en && !r_data_en_q;
    assign w_done_active = |(txn_done & w_active_oh);
    assign w_stray       = ((r_state == S_IDLE) || (r_state == S_DONE)) ? (|txn_done)
                                                                        : (|(txn_done & ~w_active_oh));
    assign w_nxt         = f_next_ch(r_active_ch);
    assign w_nxt2        = f_next_ch(w_nxt);
    assign w_fits        = ({1'b0, r_next_addr} + c_BURST_EXT) <= {1'b0, r_end};
    assign w_can_arm     = start && (w_fits || r_wrap);
    // In ring mode a burst that would overrun the window restarts at base.
    assign w_arm_addr    = w_fits ? r_next_addr : r_base;
    assign w_win_small   = {1'b0, end_addr} < ({1'b0, base_addr} + c_BURST_EXT);
    assign w_enter       = (r_state == S_WAIT_DATA) && !w_halt && w_data_rise;
    assign w_switch      = (r_state == S_STREAM) && !w_halt && w_done_active && r_armed;
    // On entry the channel after the active one is pre-armed; on a switch the
    // one after the new active channel.
    assign w_prearm_ch   = w_switch ? w_nxt2 : w_nxt;
    // A beat arriving with txn_done already belongs to the next burst.
    assign w_fwd_ch      = w_switch ? w_nxt : r_active_ch;
    assign w_fwd         = w_enter ||
                           ((r_state == S_STREAM) && !w_halt && !(w_done_active && !r_armed));

    assign wready_out = m_wready[r_active_ch];
    assign active_ch  = r_active_ch;
    assign state      = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_start_q     <= 1'b0;
            r_data_en_q   <= 1'b0;
            r_wrap        <= 1'b0;
            r_base        <= '0;
            r_end         <= '0;
            r_next_addr   <= '0;
            r_active_ch   <= '0;
            r_armed       <= 1'b0;
            init_txn      <= '0;
            ch_data_en    <= '0;
            ch_data       <= '0;
            write_done    <= 1'b0;
            halted        <= 1'b0;
            protocol_err  <= 1'b0;
            restart_count <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_bias[i] <= ADDR_WIDTH'(i * BURST_BYTES);
            end
        end else begin
            r_start_q   <= start;
            r_data_en_q <= data_en;
            ch_data     <= data;
            init_txn    <= '0;
            ch_data_en  <= (data_en && w_fwd) ? (NUM_CH'(1) << w_fwd_ch) : '0;
            if (w_stray) begin
                protocol_err <= 1'b1;
            end

            if (w_halt) begin
                r_state <= S_HALT;
                halted  <= 1'b1;
                if (restart_count != '1) begin
                    restart_count <= restart_count + 16'd1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_rise) begin
                            r_base      <= base_addr;
                            r_end       <= end_addr;
                            r_wrap      <= wrap_mode;
                            r_next_addr <= base_addr;
                            r_active_ch <= '0;
                            r_armed     <= 1'b0;
                            if (w_win_small) begin
                                r_state    <= S_DONE;
                                write_done <= 1'b1;
                            end else begin
                                r_state <= S_ARM;
                            end
                        end
                    end
                    S_ARM: begin
                        init_txn             <= w_active_oh;
                        r_bias[r_active_ch]  <= r_next_addr;
                        r_next_addr          <= r_next_addr + c_BURST_ADDR;
                        r_armed              <= 1'b0;
                        r_state              <= S_WAIT_DATA;
                    end
                    S_WAIT_DATA: begin
                        if (w_data_rise) begin
                            r_state <= S_STREAM;
                        end
                    end
                    S_STREAM: begin
                        if (w_done_active) begin
                            if (r_armed) begin
                                r_active_ch <= w_nxt;
                                r_armed     <= 1'b0;
                            end else begin
                                r_state    <= S_DONE;
                                write_done <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (!start) begin
                            r_state    <= S_IDLE;
                            write_done <= 1'b0;
                        end
                    end
                    S_HALT: begin
                        if (&w_clear_vec) begin
                            r_next_addr <= r_base;
                            r_active_ch <= '0;
                            r_armed     <= 1'b0;
                            halted      <= 1'b0;
                            r_state     <= S_ARM;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase

                // Pre-arm overrides the armed-flag clear done by a switch.
                if ((w_enter || w_switch) && w_can_arm) begin
                    init_txn            <= NUM_CH'(1) << w_prearm_ch;
                    r_bias[w_prearm_ch] <= w_arm_addr;
                    r_next_addr         <= w_arm_addr + c_BURST_ADDR;
                    r_armed             <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_multi_channel_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_burst_scheduler
// Purpose  : Self-checking bench for multi_channel_burst_scheduler with three
//            engines and 64-byte bursts. Window configurations come from a
//            table. Halt, coincidence, protocol-error and reset cases are
//            hand-written sequences. Expected arms and beats are queued when
//            stimulus is driven and are popped by a monitor.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_channel_burst_scheduler;
    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CW  = 8;
    localparam int BB  = 64;

    logic              clk = 1'b0;
    logic              rst, start, wrap_mode, data_en;
    logic [DW-1:0]     data;
    logic [AW-1:0]     base_addr, end_addr;
    logic [CW-1:0]     warn_thres, cancel_thres;
    logic [NCH*CW-1:0] fifo_cnt;
    logic [NCH-1:0]    txn_done, m_wready;
    logic [NCH-1:0]    init_txn, ch_data_en;
    logic [NCH*AW-1:0] bias_addr;
    logic [DW-1:0]     ch_data;
    logic              wready_out, write_done, halted, protocol_err;
    logic [1:0]        active_ch;
    logic [15:0]       restart_count;
    logic [2:0]        state;

    always #5 clk = ~clk;

    multi_channel_burst_scheduler #(
        .NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(16), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .wrap_mode(wrap_mode),
        .data_en(data_en), .data(data), .base_addr(base_addr), .end_addr(end_addr),
        .warn_thres(warn_thres), .cancel_thres(cancel_thres), .fifo_cnt(fifo_cnt),
        .txn_done(txn_done), .m_wready(m_wready), .init_txn(init_txn),
        .bias_addr(bias_addr), .ch_data_en(ch_data_en), .ch_data(ch_data),
        .wready_out(wready_out), .active_ch(active_ch), .write_done(write_done),
        .halted(halted), .protocol_err(protocol_err), .restart_count(restart_count),
        .state(state)
    );

    typedef struct {
        int          ch;
        logic [31:0] val;
    } ev_t;

    typedef struct {
        logic [31:0] base;
        logic [31:0] end_a;
        logic        wrap;
        int          nb;
        int          drop_at;
    } vec_t;

    ev_t  arm_q[$];
    ev_t  beat_q[$];
    ev_t  mon_a, mon_b;
    vec_t vecs[6];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_arm(input int ch, input logic [31:0] addr);
        ev_t e;
        e.ch  = ch;
        e.val = addr;
        arm_q.push_back(e);
    endtask

    task automatic send_beats(input int ch, input int n);
        ev_t e;
        for (int k = 0; k < n; k++) begin
            data_en = 1'b1;
            data    = $urandom;
            e.ch    = ch;
            e.val   = data;
            beat_q.push_back(e);
            tick();
        end
        data_en = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int k = 0;
        while (state != s && k < budget) begin
            tick();
            k++;
        end
        chk("wait_state", state, s);
    endtask

    task automatic check_reset();
        chk("rst_state", state, 0);
        chk("rst_init_txn", init_txn, 0);
        chk("rst_ch_data_en", ch_data_en, 0);
        chk("rst_ch_data", ch_data, 0);
        chk("rst_active_ch", active_ch, 0);
        chk("rst_write_done", write_done, 0);
        chk("rst_halted", halted, 0);
        chk("rst_protocol_err", protocol_err, 0);
        chk("rst_restart_count", restart_count, 0);
        for (int i = 0; i < NCH; i++) begin
            chk("rst_bias_addr", bias_addr[i*AW +: AW], 64'(i * BB));
        end
    endtask

    task automatic run_case(input vec_t v);
        longint nslots;
        int     ch;
        base_addr = v.base;
        end_addr  = v.end_a;
        wrap_mode = v.wrap;
        nslots    = (longint'(v.end_a) - longint'(v.base)) / BB;
        for (int b = 0; b < v.nb; b++) begin
            push_arm(b % NCH, v.base + 32'(BB * (b % nslots)));
        end
        start = 1'b1;
        tick();
        if (v.nb > 0) begin
            wait_state(3'd2, 8);
            for (int b = 0; b < v.nb; b++) begin
                ch = b % NCH;
                send_beats(ch, 4);
                if (b == v.drop_at) start = 1'b0;
                txn_done = 3'(1 << ch);
                tick();
                txn_done = '0;
                if (b < v.nb - 1) chk("switch_ch", active_ch, (b + 1) % NCH);
            end
        end
        chk("done_state", state, 4);
        chk("write_done", write_done, 1);
        if (start) begin
            tick();
            chk("done_hold", state, 4);
        end
        start = 1'b0;
        tick();
        chk("idle_state", state, 0);
        chk("write_done_clr", write_done, 0);
        chk("arm_q_empty", arm_q.size(), 0);
        chk("beat_q_empty", beat_q.size(), 0);
        chk("no_protocol_err", protocol_err, 0);
    endtask

    // Monitor: every arm pulse and forwarded beat must match the next queued entry.
    always @(negedge clk) begin
        if (init_txn != '0) begin
            if (arm_q.size() == 0) begin
                chk("arm_extra", init_txn, 0);
            end else begin
                mon_a = arm_q.pop_front();
                chk("arm_onehot", init_txn, 64'(1) << mon_a.ch);
                chk("arm_addr", bias_addr[mon_a.ch*AW +: AW], mon_a.val);
            end
        end
        if (ch_data_en != '0) begin
            if (beat_q.size() == 0) begin
                chk("beat_extra", ch_data_en, 0);
            end else begin
                mon_b = beat_q.pop_front();
                chk("beat_ch", ch_data_en, 64'(1) << mon_b.ch);
                chk("beat_data", ch_data, mon_b.val);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h0000_1000, 32'h0000_1100, 1'b0, 4, -1};
        vecs[1] = '{32'h0000_2000, 32'h0000_203F, 1'b0, 0, -1};
        vecs[2] = '{32'h0000_2000, 32'h0000_2040, 1'b0, 1, -1};
        vecs[3] = '{32'hFFFF_FF80, 32'hFFFF_FFFF, 1'b0, 1, -1};
        vecs[4] = '{32'h0000_1000, 32'h0000_1100, 1'b1, 6,  4};
        vecs[5] = '{32'h0000_3000, 32'h0000_30C0, 1'b0, 3, -1};

        rst = 1'b1; start = 1'b0; wrap_mode = 1'b0; data_en = 1'b0; data = '0;
        base_addr = '0; end_addr = '0; warn_thres = 8'd200; cancel_thres = 8'd50;
        fifo_cnt = '0; txn_done = '0; m_wready = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset();

        for (int i = 0; i < 6; i++) begin
            run_case(vecs[i]);
        end

        // Halt / restart sequence.
        base_addr = 32'h1000; end_addr = 32'h1100; wrap_mode = 1'b0;
        push_arm(0, 32'h1000);
        push_arm(1, 32'h1040);
        start = 1'b1;
        tick();
        wait_state(3'd2, 8);
        send_beats(0, 3);
        // Beat in the switch cycle goes to the new channel.
        push_arm(2, 32'h1080);
        data_en = 1'b1; data = $urandom; txn_done = 3'b001;
        mon_b.ch = 1; mon_b.val = data;
        beat_q.push_back(mon_b);
        tick();
        data_en = 1'b0; txn_done = '0;
        chk("switch_to_ch1", active_ch, 1);
        send_beats(1, 2);
        // Warning with a beat present: beat is dropped.
        data_en = 1'b1; data = $urandom; fifo_cnt = {8'd210, 8'd0, 8'd0};
        tick();
        data_en = 1'b0;
        chk("halt_state", state, 5);
        chk("halt_flag", halted, 1);
        chk("halt_ch_data_en", ch_data_en, 0);
        chk("halt_restart_count", restart_count, 1);
        fifo_cnt = {8'd100, 8'd0, 8'd0};
        tick(); tick();
        chk("halt_hold_100", state, 5);
        fifo_cnt = {8'd51, 8'd0, 8'd0};
        tick();
        chk("halt_hold_51", state, 5);
        fifo_cnt = {8'd50, 8'd0, 8'd0};
        push_arm(0, 32'h1000);
        tick();
        chk("restart_arm_state", state, 1);
        chk("restart_halted_clr", halted, 0);
        chk("restart_active_ch", active_ch, 0);
        push_arm(1, 32'h1040);
        wait_state(3'd2, 4);
        send_beats(0, 2);

        // Combinational WREADY mux.
        m_wready = 3'b001; #1;
        chk("wready_sel", wready_out, 1);
        m_wready = 3'b110; #1;
        chk("wready_unsel", wready_out, 0);

        // Stray txn_done on a non-active channel.
        txn_done = 3'b100;
        tick();
        txn_done = '0;
        chk("perr_set", protocol_err, 1);
        chk("perr_state", state, 3);
        chk("perr_active", active_ch, 0);

        // txn_done and warning together: halt wins, no switch.
        txn_done = 3'b001; fifo_cnt = {8'd0, 8'd0, 8'd220};
        tick();
        txn_done = '0;
        chk("coinc_state", state, 5);
        chk("coinc_active", active_ch, 0);
        chk("coinc_restart_count", restart_count, 2);
        fifo_cnt = '0;
        push_arm(0, 32'h1000);
        tick();
        chk("coinc_rearm", state, 1);
        push_arm(1, 32'h1040);
        wait_state(3'd2, 4);
        send_beats(0, 2);
        chk("stream_before_rst", state, 3);

        // Mid-run reset.
        rst = 1'b1; start = 1'b0; data_en = 1'b1; data = $urandom;
        tick();
        rst = 1'b0; data_en = 1'b0;
        check_reset();
        chk("rst_bias1", bias_addr[AW +: AW], 32'h40);

        // txn_done while idle.
        txn_done = 3'b010;
        tick();
        txn_done = '0;
        chk("perr_idle", protocol_err, 1);
        chk("perr_idle_state", state, 0);
        tick();
        chk("final_arm_q", arm_q.size(), 0);
        chk("final_beat_q", beat_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
